// File: rtl/rob_squash.sv
// rob_squash: parametrised N-way reorder buffer with branch-mispredict squash.
// Dispatch writes in order at tail, the CDB marks entries complete, and the
// oldest completed entries retire in order from head. A retiring mispredicted
// branch raises flush and empties the whole buffer at that edge.
module rob_squash #(
  parameter int N_WAY    = 2,
  parameter int N_ROB    = 16,
  parameter int TAG_BITS = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_WAY-1:0]              dis_valid,
  input  logic [N_WAY*TAG_BITS-1:0]     dis_tag,
  input  logic [N_WAY*TAG_BITS-1:0]     dis_told,
  input  logic [N_WAY*TAG_BITS-1:0]     cdb_tag,
  input  logic [N_WAY-1:0]              cdb_mispredict,
  output logic [N_WAY-1:0]              dispatched,
  output logic [$clog2(N_WAY):0]        empty_slots,
  output logic [N_WAY-1:0]              retire_valid,
  output logic [N_WAY*TAG_BITS-1:0]     retire_tag,
  output logic [N_WAY*TAG_BITS-1:0]     retire_told,
  output logic                          flush,
  output logic [$clog2(N_ROB):0]        count
);

  localparam int IW = $clog2(N_ROB);
  localparam int CW = IW + 1;
  localparam int EW = $clog2(N_WAY) + 1;

  logic [N_ROB-1:0]    valid_q, valid_d;
  logic [N_ROB-1:0]    complete_q, complete_d;
  logic [N_ROB-1:0]    mispred_q, mispred_d;
  logic [TAG_BITS-1:0] tag_q  [N_ROB];
  logic [TAG_BITS-1:0] tag_d  [N_ROB];
  logic [TAG_BITS-1:0] told_q [N_ROB];
  logic [TAG_BITS-1:0] told_d [N_ROB];
  logic [IW-1:0]       head_q, head_d;
  logic [IW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;

  logic [CW-1:0]       free_w;
  logic [CW-1:0]       n_ret;
  logic [CW-1:0]       n_acc;

  assign count  = count_q;
  // Free space is taken from the start-of-cycle count; same-cycle retires do not help.
  assign free_w = CW'(N_ROB) - count_q;

  // Report min(free, N_WAY); pinned to N_WAY while in reset.
  always_comb begin
    empty_slots = EW'(N_WAY);
    if (!reset && (free_w < CW'(N_WAY))) begin
      empty_slots = EW'(free_w);
    end
  end

  // In-order retire from head; a mispredicted entry is the last lane to retire.
  always_comb begin
    logic          chain;
    logic          ok;
    logic [IW-1:0] ridx;
    chain        = 1'b1;
    n_ret        = '0;
    flush        = 1'b0;
    retire_valid = '0;
    retire_tag   = '0;
    retire_told  = '0;
    for (int k = 0; k < N_WAY; k++) begin
      ridx = head_q + IW'(k);
      ok   = chain && valid_q[ridx] && complete_q[ridx] && !reset;
      if (ok) begin
        retire_valid[k]                          = 1'b1;
        retire_tag[k*TAG_BITS +: TAG_BITS]       = tag_q[ridx];
        retire_told[k*TAG_BITS +: TAG_BITS]      = told_q[ridx];
        n_ret                                    = n_ret + CW'(1);
        if (mispred_q[ridx]) begin
          flush = 1'b1;
        end
      end
      chain = ok && !mispred_q[ridx];
    end
  end

  // In-order dispatch acceptance; a rejected lane blocks every higher lane.
  always_comb begin
    logic chain;
    logic ok;
    chain      = 1'b1;
    n_acc      = '0;
    dispatched = '0;
    for (int i = 0; i < N_WAY; i++) begin
      ok = chain && dis_valid[i] && (dis_tag[i*TAG_BITS +: TAG_BITS] != '0)
           && (CW'(i) < free_w) && !flush && !reset;
      dispatched[i] = ok;
      if (ok) begin
        n_acc = n_acc + CW'(1);
      end
      chain = ok;
    end
  end

  // Entry and pointer next-state: completion, then retire, then dispatch, then squash.
  always_comb begin
    logic [IW-1:0] widx;
    widx       = '0;
    valid_d    = valid_q;
    complete_d = complete_q;
    mispred_d  = mispred_q;
    tag_d      = tag_q;
    told_d     = told_q;
    head_d     = head_q + IW'(n_ret);
    tail_d     = tail_q + IW'(n_acc);
    count_d    = count_q + n_acc - n_ret;

    for (int e = 0; e < N_ROB; e++) begin
      for (int l = 0; l < N_WAY; l++) begin
        if (valid_q[e] && (cdb_tag[l*TAG_BITS +: TAG_BITS] != '0)
            && (tag_q[e] == cdb_tag[l*TAG_BITS +: TAG_BITS])) begin
          complete_d[e] = 1'b1;
          if (cdb_mispredict[l]) begin
            mispred_d[e] = 1'b1;
          end
        end
      end
    end

    for (int k = 0; k < N_WAY; k++) begin
      if (retire_valid[k]) begin
        valid_d[head_q + IW'(k)] = 1'b0;
      end
    end

    // Dispatch targets only free slots, so it never collides with a match above.
    for (int i = 0; i < N_WAY; i++) begin
      if (dispatched[i]) begin
        widx             = tail_q + IW'(i);
        valid_d[widx]    = 1'b1;
        complete_d[widx] = 1'b0;
        mispred_d[widx]  = 1'b0;
        tag_d[widx]      = dis_tag[i*TAG_BITS +: TAG_BITS];
        told_d[widx]     = dis_told[i*TAG_BITS +: TAG_BITS];
      end
    end

    if (reset || flush) begin
      valid_d    = '0;
      complete_d = '0;
      mispred_d  = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end
  end

  // State registers; tag/told payload needs no reset since valid gates it.
  always_ff @(posedge clock) begin
    valid_q    <= valid_d;
    complete_q <= complete_d;
    mispred_q  <= mispred_d;
    tag_q      <= tag_d;
    told_q     <= told_d;
    head_q     <= head_d;
    tail_q     <= tail_d;
    count_q    <= count_d;
  end

endmodule
